// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the initiator state encoding.
// Also holds the command legality check used by the initiator.
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   localparam logic [2:0] HBURST_SINGLE   = 3'b000;
   localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;
   localparam logic       HRESP_OKAY      = 1'b0;
   localparam logic       HRESP_ERROR     = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2,
      ST_RESP = 2'd3
   } state_t;

   // Size 3 is never legal; halfwords and words must be naturally aligned.
   function automatic logic cmd_illegal(input logic [1:0] size, input logic [1:0] addr_lsb);
      logic bad;
      case (size)
         2'd0:    bad = 1'b0;
         2'd1:    bad = addr_lsb[0];
         2'd2:    bad = (addr_lsb != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/ahb_lite_master.sv
// Single-outstanding AHB-Lite initiator: one valid/ready command becomes one
// SINGLE transfer, answered by one response; all outputs are registered.
module ahb_lite_master
   import ahb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int WAIT_CNT_W = 16
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_W-1:0]     cmd_addr,
   input  logic [1:0]            cmd_size,
   input  logic [DATA_W-1:0]     cmd_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic                  rsp_error,
   output logic [WAIT_CNT_W-1:0] wait_cycles,
   output logic [ADDR_W-1:0]     HADDR,
   output logic [1:0]            HTRANS,
   output logic                  HWRITE,
   output logic [2:0]            HSIZE,
   output logic [2:0]            HBURST,
   output logic [3:0]            HPROT,
   output logic [DATA_W-1:0]     HWDATA,
   input  logic [DATA_W-1:0]     HRDATA,
   input  logic                  HREADY,
   input  logic                  HRESP
);

   state_t                  state_reg, state_next;
   logic [1:0]              htrans_reg, htrans_next;
   logic [ADDR_W-1:0]       haddr_reg, haddr_next;
   logic                    hwrite_reg, hwrite_next;
   logic [2:0]              hsize_reg, hsize_next;
   logic [DATA_W-1:0]       hwdata_reg, hwdata_next;
   logic [DATA_W-1:0]       wdata_reg, wdata_next;
   logic                    err_seen_reg, err_seen_next;
   logic                    cmd_ready_reg, cmd_ready_next;
   logic                    rsp_valid_reg, rsp_valid_next;
   logic [DATA_W-1:0]       rsp_rdata_reg, rsp_rdata_next;
   logic                    rsp_error_reg, rsp_error_next;
   logic [WAIT_CNT_W-1:0]   wait_reg, wait_next;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_reg     <= ST_IDLE;
         htrans_reg    <= HTRANS_IDLE;
         haddr_reg     <= '0;
         hwrite_reg    <= 1'b0;
         hsize_reg     <= HSIZE_BYTE;
         hwdata_reg    <= '0;
         wdata_reg     <= '0;
         err_seen_reg  <= 1'b0;
         cmd_ready_reg <= 1'b1;
         rsp_valid_reg <= 1'b0;
         rsp_rdata_reg <= '0;
         rsp_error_reg <= 1'b0;
         wait_reg      <= '0;
      end else begin
         state_reg     <= state_next;
         htrans_reg    <= htrans_next;
         haddr_reg     <= haddr_next;
         hwrite_reg    <= hwrite_next;
         hsize_reg     <= hsize_next;
         hwdata_reg    <= hwdata_next;
         wdata_reg     <= wdata_next;
         err_seen_reg  <= err_seen_next;
         cmd_ready_reg <= cmd_ready_next;
         rsp_valid_reg <= rsp_valid_next;
         rsp_rdata_reg <= rsp_rdata_next;
         rsp_error_reg <= rsp_error_next;
         wait_reg      <= wait_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      htrans_next    = htrans_reg;
      haddr_next     = haddr_reg;
      hwrite_next    = hwrite_reg;
      hsize_next     = hsize_reg;
      hwdata_next    = hwdata_reg;
      wdata_next     = wdata_reg;
      err_seen_next  = err_seen_reg;
      rsp_valid_next = rsp_valid_reg;
      rsp_rdata_next = rsp_rdata_reg;
      rsp_error_next = rsp_error_reg;
      wait_next      = wait_reg;

      case (state_reg)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready_reg) begin
               if (cmd_illegal(cmd_size, cmd_addr[1:0])) begin
                  // Rejected locally: the bus never sees this command.
                  state_next     = ST_RESP;
                  rsp_valid_next = 1'b1;
                  rsp_error_next = 1'b1;
                  rsp_rdata_next = '0;
               end else begin
                  state_next    = ST_ADDR;
                  htrans_next   = HTRANS_NONSEQ;
                  haddr_next    = cmd_addr;
                  hwrite_next   = cmd_write;
                  hsize_next    = {1'b0, cmd_size};
                  wdata_next    = cmd_wdata;
                  err_seen_next = 1'b0;
               end
            end
         end
         ST_ADDR: begin
            if (HREADY) begin
               state_next  = ST_DATA;
               htrans_next = HTRANS_IDLE;
               wait_next   = '0;
               if (hwrite_reg) hwdata_next = wdata_reg;
            end
         end
         ST_DATA: begin
            if (!HREADY) begin
               if (wait_reg != '1) wait_next = wait_reg + WAIT_CNT_W'(1);
               if (HRESP == HRESP_ERROR) err_seen_next = 1'b1;
            end else begin
               state_next     = ST_RESP;
               rsp_valid_next = 1'b1;
               rsp_error_next = err_seen_reg | HRESP;
               rsp_rdata_next = (hwrite_reg || err_seen_reg || HRESP) ? '0 : HRDATA;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_next     = ST_IDLE;
               rsp_valid_next = 1'b0;
            end
         end
         default: state_next = ST_IDLE;
      endcase

      cmd_ready_next = (state_next == ST_IDLE);
   end

   assign cmd_ready   = cmd_ready_reg;
   assign rsp_valid   = rsp_valid_reg;
   assign rsp_rdata   = rsp_rdata_reg;
   assign rsp_error   = rsp_error_reg;
   assign wait_cycles = wait_reg;
   assign HADDR       = haddr_reg;
   assign HTRANS      = htrans_reg;
   assign HWRITE      = hwrite_reg;
   assign HSIZE       = hsize_reg;
   assign HBURST      = HBURST_SINGLE;
   assign HPROT       = HPROT_DATA_PRIV;
   assign HWDATA      = hwdata_reg;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed, table-driven bench for ahb_lite_master with a cycle-scripted slave.
module tb_ahb_lite_master;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [1:0]  cmd_size;
   logic        rsp_valid, rsp_ready, rsp_error;
   logic [31:0] rsp_rdata;
   logic [15:0] wait_cycles;
   logic [31:0] HADDR, HWDATA, HRDATA;
   logic [1:0]  HTRANS;
   logic        HWRITE, HREADY, HRESP;
   logic [2:0]  HSIZE, HBURST;
   logic [3:0]  HPROT;

   int n_chk  = 0;
   int n_fail = 0;

   ahb_lite_master dut (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_error(rsp_error), .wait_cycles(wait_cycles),
      .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
      .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
      .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
   );

   always #5 HCLK = ~HCLK;

   typedef struct {
      logic        write;
      logic [31:0] addr;
      logic [1:0]  size;
      logic [31:0] wdata;
      logic [31:0] hrdata;
      int          waits;
      logic        slv_err;
      int          hold;
      logic        illegal;
      logic [31:0] exp_rdata;
      logic        exp_err;
      logic [15:0] exp_waits;
      int          exp_lat;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (vec %0d): got %h, expected %h", name, idx, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int cyc;
      chk("cmd_ready_idle", idx, 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      cmd_write = v.write;
      cmd_addr  = v.addr;
      cmd_size  = v.size;
      cmd_wdata = v.wdata;
      @(posedge HCLK); #1;
      cmd_valid = 1'b0;
      cmd_wdata = 32'h0;
      cyc = 1;
      if (!v.illegal) begin
         chk("htrans_nonseq", idx, 32'(HTRANS), 32'd2);
         chk("haddr", idx, HADDR, v.addr);
         chk("hwrite", idx, 32'(HWRITE), 32'(v.write));
         chk("hsize", idx, 32'(HSIZE), 32'({1'b0, v.size}));
         chk("cmd_ready_busy", idx, 32'(cmd_ready), 32'd0);
         @(posedge HCLK); #1; cyc++;
         chk("htrans_data", idx, 32'(HTRANS), 32'd0);
         for (int w = 0; w < v.waits; w++) begin
            HREADY = 1'b0;
            HRESP  = v.slv_err && (w == v.waits - 1);
            if (v.write) chk("hwdata_wait", idx, HWDATA, v.wdata);
            chk("rsp_valid_wait", idx, 32'(rsp_valid), 32'd0);
            @(posedge HCLK); #1; cyc++;
            chk("htrans_wait", idx, 32'(HTRANS), 32'd0);
         end
         HREADY = 1'b1;
         HRESP  = v.slv_err;
         HRDATA = v.hrdata;
         if (v.write) chk("hwdata_last", idx, HWDATA, v.wdata);
         @(posedge HCLK); #1; cyc++;
         HRESP  = 1'b0;
         HRDATA = 32'hFFFF_FFFF;
      end else begin
         chk("htrans_illegal", idx, 32'(HTRANS), 32'd0);
      end
      chk("rsp_valid", idx, 32'(rsp_valid), 32'd1);
      chk("latency", idx, 32'(cyc), 32'(v.exp_lat));
      chk("rsp_rdata", idx, rsp_rdata, v.exp_rdata);
      chk("rsp_error", idx, 32'(rsp_error), 32'(v.exp_err));
      if (!v.illegal) chk("wait_cycles", idx, 32'(wait_cycles), 32'(v.exp_waits));
      for (int h = 0; h < v.hold; h++) begin
         @(posedge HCLK); #1;
         chk("hold_valid", idx, 32'(rsp_valid), 32'd1);
         chk("hold_rdata", idx, rsp_rdata, v.exp_rdata);
         chk("hold_error", idx, 32'(rsp_error), 32'(v.exp_err));
         chk("hold_cmd_ready", idx, 32'(cmd_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge HCLK); #1;
      rsp_ready = 1'b0;
      chk("rsp_valid_clr", idx, 32'(rsp_valid), 32'd0);
      chk("cmd_ready_after", idx, 32'(cmd_ready), 32'd1);
      if (v.write && !v.illegal) chk("hwdata_kept", idx, HWDATA, v.wdata);
      $display("vec %0d: write=%0b addr=%h size=%0d rdata=%h err=%0b waits=%0d lat=%0d",
               idx, v.write, v.addr, v.size, rsp_rdata, rsp_error, wait_cycles, cyc);
   endtask

   initial begin
      // write addr size wdata hrdata waits err hold illegal | rdata err waits lat
      vecs[0] = '{1'b0, 32'h5200_0000, 2'd2, 32'h0, 32'h0000_1234, 0, 1'b0, 0, 1'b0, 32'h0000_1234, 1'b0, 16'd0, 3};
      vecs[1] = '{1'b1, 32'h5000_0004, 2'd2, 32'hDEAD_BEEF, 32'hCAFE_0000, 3, 1'b0, 0, 1'b0, 32'h0, 1'b0, 16'd3, 6};
      vecs[2] = '{1'b0, 32'h5000_0008, 2'd2, 32'h0, 32'hBAD0_0BAD, 1, 1'b1, 0, 1'b0, 32'h0, 1'b1, 16'd1, 4};
      vecs[3] = '{1'b0, 32'h5000_0003, 2'd0, 32'h0, 32'h0000_00AB, 0, 1'b0, 0, 1'b0, 32'h0000_00AB, 1'b0, 16'd0, 3};
      vecs[4] = '{1'b1, 32'h5000_0001, 2'd0, 32'h0000_0011, 32'h0, 0, 1'b0, 0, 1'b0, 32'h0, 1'b0, 16'd0, 3};
      vecs[5] = '{1'b0, 32'h5000_0002, 2'd2, 32'h0, 32'h0, 0, 1'b0, 0, 1'b1, 32'h0, 1'b1, 16'd0, 1};
      vecs[6] = '{1'b1, 32'h0000_0000, 2'd3, 32'h1, 32'h0, 0, 1'b0, 0, 1'b1, 32'h0, 1'b1, 16'd0, 1};
      vecs[7] = '{1'b0, 32'h5000_0001, 2'd1, 32'h0, 32'h0, 0, 1'b0, 0, 1'b1, 32'h0, 1'b1, 16'd0, 1};
      vecs[8] = '{1'b0, 32'h5000_0002, 2'd1, 32'h0, 32'h0000_5678, 2, 1'b0, 5, 1'b0, 32'h0000_5678, 1'b0, 16'd2, 5};

      HRESETn = 1'b1;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_size = 2'd0; cmd_wdata = 32'h0;
      rsp_ready = 1'b0; HRDATA = 32'h0; HREADY = 1'b1; HRESP = 1'b0;
      #2 HRESETn = 1'b0;
      repeat (2) @(posedge HCLK);
      #1;
      chk("rst_htrans", -1, 32'(HTRANS), 32'd0);
      chk("rst_cmd_ready", -1, 32'(cmd_ready), 32'd1);
      chk("rst_rsp_valid", -1, 32'(rsp_valid), 32'd0);
      chk("rst_haddr", -1, HADDR, 32'h0);
      chk("rst_wait", -1, 32'(wait_cycles), 32'd0);
      chk("hburst", -1, 32'(HBURST), 32'd0);
      chk("hprot", -1, 32'(HPROT), 32'd3);
      @(negedge HCLK) HRESETn = 1'b1;
      @(posedge HCLK); #1;

      for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

      // Reset while the data phase is being stretched by the slave.
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h5000_0010; cmd_size = 2'd2;
      @(posedge HCLK); #1;
      cmd_valid = 1'b0;
      @(posedge HCLK); #1;
      HREADY = 1'b0;
      @(posedge HCLK); #1;
      chk("pre_rst_wait", 9, 32'(wait_cycles), 32'd1);
      HRESETn = 1'b0;
      #1;
      chk("arst_htrans", 9, 32'(HTRANS), 32'd0);
      chk("arst_haddr", 9, HADDR, 32'h0);
      chk("arst_hwrite", 9, 32'(HWRITE), 32'd0);
      chk("arst_hsize", 9, 32'(HSIZE), 32'd0);
      chk("arst_hwdata", 9, HWDATA, 32'h0);
      chk("arst_cmd_ready", 9, 32'(cmd_ready), 32'd1);
      chk("arst_rsp_valid", 9, 32'(rsp_valid), 32'd0);
      chk("arst_rsp_rdata", 9, rsp_rdata, 32'h0);
      chk("arst_rsp_error", 9, 32'(rsp_error), 32'd0);
      chk("arst_wait", 9, 32'(wait_cycles), 32'd0);
      HREADY = 1'b1;
      @(negedge HCLK) HRESETn = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge HCLK); #1;
         chk("post_rst_valid", 9, 32'(rsp_valid), 32'd0);
         chk("post_rst_ready", 9, 32'(cmd_ready), 32'd1);
         chk("post_rst_htrans", 9, 32'(HTRANS), 32'd0);
      end
      $display("reset during data phase: cmd_ready=%0b rsp_valid=%0b", cmd_ready, rsp_valid);

      run_vec(vecs[0], 10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
